// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store funct3 codes,
// FSM state encoding and the byte-lane / load-extension helpers.
package dmem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP
   } state_t;

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 4'b0001 << lo;
         SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [2:0] funct3);
      logic [31:0] sh;
      sh = word >> {lo, 3'b000};
      case (funct3[1:0])
         SZ_BYTE: return funct3[2] ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: return funct3[2] ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
         SZ_WORD: return sh;
         default: return 32'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Memory-stage request/response bus between the pipeline (master) and the
// data-memory responder (slave).
interface data_memory_responder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [2:0]  req_funct3_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        stall_o;

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o
   );

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_funct3_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o
   );
endinterface

// File: rtl/dmem_bram.sv
// Single-port word RAM with per-byte write enables and a registered read port,
// written so synthesis maps it onto block RAM. Contents are never reset.
module dmem_bram #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic [3:0]                     we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: decodes RV32 load/store requests, accesses the RAM and
// returns a single-cycle response while stalling the pipeline until then.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready; legal store commits / legal load read issued on accept
// ST_ACCESS | RAM read data available, load result registered
// ST_WAIT   | optional extra latency, wait_cnt counts down to 0
// ST_RESP   | rsp_valid_o pulse, stall released
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input logic                    clk_i,
   input logic                    reset_i,
   data_memory_responder_if.slave bus
);

   localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) * 32'd4;
   localparam logic [2:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   state_t      state, state_next;
   logic [2:0]  wait_cnt;
   logic [1:0]  lo_q;
   logic [2:0]  f3_q;
   logic        wr_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] offset;
   logic [1:0]  size;
   logic        in_range, misaligned, illegal, req_err;
   logic        req_ready, accept;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata, ram_rdata;

   assign offset     = bus.req_addr_i - BASE_ADDR;
   assign size       = bus.req_funct3_i[1:0];
   assign in_range   = offset < SPAN_BYTES;
   assign misaligned = (size == SZ_HALF && bus.req_addr_i[0]) ||
                       (size == SZ_WORD && bus.req_addr_i[1:0] != 2'b00);
   // unsigned variants exist only for LB/LH; stores never take funct3[2]
   assign illegal    = (size == 2'b11) ||
                       (bus.req_funct3_i[2] && (bus.req_write_i || size == SZ_WORD));
   assign req_err    = ~in_range | misaligned | illegal;

   assign req_ready  = (state == ST_IDLE) & ~reset_i;
   assign accept     = bus.req_valid_i & req_ready;

   assign ram_en     = accept & ~req_err;
   assign ram_we     = bus.req_write_i ? byte_enables(size, bus.req_addr_i[1:0]) : 4'b0000;
   assign ram_wdata  = bus.req_wdata_i << {bus.req_addr_i[1:0], 3'b000};

   dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
      .clk   (clk_i),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (offset[ADDR_W+1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept) state_next = req_err ? ST_RESP : ST_ACCESS;
         ST_ACCESS: state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
         ST_WAIT:   if (wait_cnt == 3'd0) state_next = ST_RESP;
         ST_RESP:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= ST_IDLE;
         wait_cnt <= 3'd0;
         lo_q     <= 2'b00;
         f3_q     <= 3'b000;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'b0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lo_q    <= bus.req_addr_i[1:0];
                  f3_q    <= bus.req_funct3_i;
                  wr_q    <= bus.req_write_i;
                  err_q   <= req_err;
                  rdata_q <= 32'b0;
               end
            end
            ST_ACCESS: begin
               rdata_q  <= wr_q ? 32'b0 : load_extract(ram_rdata, lo_q, f3_q);
               wait_cnt <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
            end
            ST_RESP: begin
               rdata_q <= 32'b0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = (state == ST_RESP);
   assign bus.rsp_rdata_o = rdata_q;
   assign bus.rsp_err_o   = err_q;
   assign bus.stall_o     = reset_i ? bus.req_valid_i :
                            ((state == ST_ACCESS) || (state == ST_WAIT) ||
                             (state == ST_IDLE && bus.req_valid_i));

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (no extra latency and 3 wait cycles),
// a vector table driven through a response scoreboard, plus reset corner sequences.
module tb_data_memory_responder;
   import dmem_pkg::*;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset0, reset3;
   logic        sel, valid, wr;
   logic [31:0] addr, wdata;
   logic [2:0]  f3;

   data_memory_responder_if bus0();
   data_memory_responder_if bus3();

   data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .reset_i(reset0), .bus(bus0.slave));
   data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .reset_i(reset3), .bus(bus3.slave));

   assign bus0.req_valid_i  = valid & ~sel;
   assign bus3.req_valid_i  = valid & sel;
   assign bus0.req_write_i  = wr;
   assign bus3.req_write_i  = wr;
   assign bus0.req_addr_i   = addr;
   assign bus3.req_addr_i   = addr;
   assign bus0.req_wdata_i  = wdata;
   assign bus3.req_wdata_i  = wdata;
   assign bus0.req_funct3_i = f3;
   assign bus3.req_funct3_i = f3;

   logic        o_ready, o_stall, o_rsp_valid, o_err;
   logic [31:0] o_rdata;
   assign o_ready     = sel ? bus3.req_ready_o : bus0.req_ready_o;
   assign o_stall     = sel ? bus3.stall_o     : bus0.stall_o;
   assign o_rsp_valid = sel ? bus3.rsp_valid_o : bus0.rsp_valid_o;
   assign o_err       = sel ? bus3.rsp_err_o   : bus0.rsp_err_o;
   assign o_rdata     = sel ? bus3.rsp_rdata_o : bus0.rsp_rdata_o;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      bit          s;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
      logic [31:0] er;
      bit          ee;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_vec = 0, n_miss = 0, n_checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_req(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic [31:0] er, input bit ee);
      int   lat;
      int   n;
      exp_t e;
      lat = ee ? 1 : (2 + (s ? 3 : 0));
      n_vec++;
      sb.push_back('{rdata: er, err: ee});
      @(posedge clk); #1;
      sel = s; wr = w; addr = a; wdata = d; f3 = f; valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 32'(o_ready), 32'd1);
      for (int k = 0; k <= lat; k++) begin
         if (k > 0) @(negedge clk);
         chk("stall", 32'(o_stall), 32'(k < lat));
         chk("rsp_valid", 32'(o_rsp_valid), 32'(k == lat));
      end
      e = sb.pop_front();
      chk("rsp_rdata", o_rdata, e.rdata);
      chk("rsp_err", 32'(o_err), 32'(e.err));
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      chk("rsp_valid_clear", 32'(o_rsp_valid), 32'd0);
      chk("rdata_clear", o_rdata, 32'd0);
      chk("err_clear", 32'(o_err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      sel = 1'b0; valid = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = '0;
      reset0 = 1'b1; reset3 = 1'b1;

      //            s  w  addr               wdata           f3      exp rdata      err
      vecs.push_back('{0, 1, BASE + 32'h10,   32'h1234_5678, F3_SW,  32'h0,          0});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         F3_LW,  32'h1234_5678,  0});
      vecs.push_back('{0, 1, BASE + 32'h10,   32'h1122_3344, F3_SW,  32'h0,          0});
      vecs.push_back('{0, 1, BASE + 32'h13,   32'h0000_00AB, F3_SB,  32'h0,          0});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         F3_LW,  32'hAB22_3344,  0});
      vecs.push_back('{0, 0, BASE + 32'h13,   32'h0,         F3_LB,  32'hFFFF_FFAB,  0});
      vecs.push_back('{0, 0, BASE + 32'h13,   32'h0,         F3_LBU, 32'h0000_00AB,  0});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         F3_LB,  32'h0000_0044,  0});
      vecs.push_back('{0, 1, BASE + 32'h12,   32'h0000_8001, F3_SH,  32'h0,          0});
      vecs.push_back('{0, 0, BASE + 32'h12,   32'h0,         F3_LH,  32'hFFFF_8001,  0});
      vecs.push_back('{0, 0, BASE + 32'h12,   32'h0,         F3_LHU, 32'h0000_8001,  0});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         F3_LH,  32'h0000_3344,  0});
      vecs.push_back('{0, 0, BASE + 32'h11,   32'h0,         F3_LH,  32'h0,          1});
      vecs.push_back('{0, 1, BASE + 32'h10,   32'hFFFF_FFFF, 3'b101, 32'h0,          1});
      vecs.push_back('{0, 0, BASE + 32'h12,   32'h0,         F3_LW,  32'h0,          1});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         3'b011, 32'h0,          1});
      vecs.push_back('{0, 0, BASE + 32'h10,   32'h0,         F3_LW,  32'h8001_3344,  0});
      vecs.push_back('{0, 1, BASE,            32'h55AA_55AA, F3_SW,  32'h0,          0});
      vecs.push_back('{0, 1, BASE + 32'h1000, 32'hDEAD_BEEF, F3_SW,  32'h0,          1});
      vecs.push_back('{0, 1, BASE - 32'h4,    32'hDEAD_BEEF, F3_SW,  32'h0,          1});
      vecs.push_back('{0, 0, BASE,            32'h0,         F3_LW,  32'h55AA_55AA,  0});
      vecs.push_back('{0, 1, BASE + 32'hFFC,  32'h0BAD_F00D, F3_SW,  32'h0,          0});
      vecs.push_back('{0, 0, BASE + 32'hFFC,  32'h0,         F3_LW,  32'h0BAD_F00D,  0});
      vecs.push_back('{0, 0, BASE + 32'hFFF,  32'h0,         F3_LBU, 32'h0000_000B,  0});
      vecs.push_back('{1, 1, BASE + 32'h20,   32'h0102_0304, F3_SW,  32'h0,          0});
      vecs.push_back('{1, 0, BASE + 32'h20,   32'h0,         F3_LW,  32'h0102_0304,  0});
      vecs.push_back('{1, 0, BASE + 32'h22,   32'h0,         F3_LHU, 32'h0000_0102,  0});
      vecs.push_back('{1, 0, BASE + 32'h21,   32'h0,         F3_LW,  32'h0,          1});

      repeat (3) @(posedge clk);
      #1;
      reset0 = 1'b0; reset3 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sel = (i == 1);
         @(negedge clk);
         chk("reset_ready", 32'(o_ready), 32'd1);
         chk("reset_stall", 32'(o_stall), 32'd0);
         chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
         chk("reset_rdata", o_rdata, 32'd0);
         chk("reset_err", 32'(o_err), 32'd0);
      end

      foreach (vecs[i])
         run_req(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].f, vecs[i].er, vecs[i].ee);

      // reset raised the cycle after a store is accepted: no response, store stays committed
      n_vec++;
      @(posedge clk); #1;
      sel = 1'b1; wr = 1'b1; addr = BASE + 32'h24; wdata = 32'hCAFE_F00D; f3 = F3_SW; valid = 1'b1;
      @(negedge clk);
      chk("midrst_accept_ready", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      reset3 = 1'b1; valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
         chk("midrst_rdata", o_rdata, 32'd0);
         chk("midrst_err", 32'(o_err), 32'd0);
         chk("midrst_stall", 32'(o_stall), 32'd0);
         if (k < 2) chk("midrst_ready", 32'(o_ready), 32'd0);
         if (k == 1) begin
            @(posedge clk); #1;
            reset3 = 1'b0;
         end
      end
      run_req(1, 0, BASE + 32'h24, 32'h0, F3_LW, 32'hCAFE_F00D, 0);

      // reset together with a valid store: not accepted, memory untouched
      n_vec++;
      @(posedge clk); #1;
      sel = 1'b0; reset0 = 1'b1;
      wr = 1'b1; addr = BASE + 32'h10; wdata = 32'hFFFF_0000; f3 = F3_SW; valid = 1'b1;
      @(negedge clk);
      chk("rstvalid_ready", 32'(o_ready), 32'd0);
      chk("rstvalid_stall", 32'(o_stall), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      chk("rstvalid_stall_low", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      reset0 = 1'b0;
      @(negedge clk);
      chk("rstvalid_rsp_valid", 32'(o_rsp_valid), 32'd0);
      run_req(0, 0, BASE + 32'h10, 32'h0, F3_LW, 32'h8001_3344, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Single-port data-memory responder that answers load/store requests issued by the processor's memory stage. It decodes RV32 load/store width from `funct3`, performs byte-lane writes and sign/zero-extending reads on an internal block RAM, and flags out-of-range, misaligned or illegal accesses. It drives a stall toward the hazard unit while a request is in flight and returns a one-cycle response pulse.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0; word-aligned.
- `WAIT_CYCLES`, 0: extra response latency in cycles, 0..7.
- `clk_i` in 1: the single clock; all state changes on its rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request present; held stable while `stall_o`=1.
- `req_ready_o` out 1: request accepted in this cycle when high together with `req_valid_i`.
- `req_write_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `req_funct3_i` in 3: RV32 load/store `funct3`.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: access fault; qualified by `rsp_valid_o`.
- `stall_o` out 1: asserted to the hazard unit while the current request is unanswered.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- `req_ready_o` = (state==IDLE) & ~`reset_i`. Accept cycle T is the cycle in which `req_valid_i` & `req_ready_o`.
- Decode at accept: `offset` = `req_addr_i` − `BASE_ADDR` (32-bit unsigned). The request is in range if `offset` < `DEPTH_WORDS`*4. Word index = `offset`[31:2].
- Size is `funct3`[1:0]: 00 = byte (any alignment), 01 = half (requires addr[0]=0), 10 = word (requires addr[1:0]=0), 11 = illegal.
- `funct3`[2]=1 means unsigned; it is legal only for loads with size 00 or 01. A store with `funct3`[2]=1 is illegal.
- Error is out of range OR misaligned OR illegal. An error request causes no RAM write and goes IDLE→RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0.
- Legal store: the RAM write commits on the accept edge using byte enables.
  - SB: lane addr[1:0] ← wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - SW: all four lanes.
- Legal load: the RAM read is issued on the accept edge. In ACCESS, the load result is registered as word >> (8·addr[1:0]), truncated to the access size, and sign- or zero-extended.
- Legal transitions: IDLE→ACCESS; ACCESS→WAIT if `WAIT_CYCLES`>0, else ACCESS→RESP; WAIT counts `WAIT_CYCLES` cycles, then WAIT→RESP.
- RESP always returns to IDLE.
- `stall_o` = (state∈{ACCESS,WAIT}) | (state==IDLE & `req_valid_i`). It is low in RESP, so the pipeline advances on the response edge. The next cycle's `req_valid_i` is a new request.
- Reset mid-operation abandons the request and no response is produced. A store already committed at the accept edge stays committed. RAM contents are never reset.
- `reset_i` together with `req_valid_i`: reset wins and the request is not accepted.

## Timing
- Reset values: state IDLE, wait counter 0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0.
- While `reset_i`=1: `req_ready_o`=0 and `stall_o` follows `req_valid_i`.
- Legal access: `rsp_valid_o` high in cycle T+2+`WAIT_CYCLES`. `stall_o` is high in cycles T..T+1+`WAIT_CYCLES`.
- Error access: `rsp_valid_o` high in cycle T+1. `stall_o` is high in cycle T only.
- `rsp_rdata_o` and `rsp_err_o` are registered and valid only while `rsp_valid_o`=1. They return to 0 in the following cycle.
- Throughput: one legal request per 3+`WAIT_CYCLES` cycles. The earliest next accept is the cycle after RESP.

## Structure
- Package `dmem_pkg` holds:
  - `funct3` constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - the state enum;
  - a function giving byte enables from size and addr[1:0];
  - a function doing load extraction and extension.
- Sub-module `dmem_bram`: single-port `DEPTH_WORDS`×32 RAM with 4-bit byte write enable and 1-cycle registered read; inferable as block RAM.

## Test plan
- SW 32'h1234_5678 to `BASE_ADDR`+0x10, then LW from the same address, `WAIT_CYCLES`=0 → store response at T+2 with `rsp_err_o`=0 and `rsp_rdata_o`=0. Load response at T+2 with `rsp_rdata_o`=32'h1234_5678.
- SW 32'h1122_3344 to +0x10, then SB 32'h0000_00AB to +0x13 → LW returns 32'hAB22_3344, LB +0x13 returns 32'hFFFF_FFAB, LBU +0x13 returns 32'h0000_00AB.
- SH 32'h0000_8001 to +0x12 → LH +0x12 returns 32'hFFFF_8001 and LHU +0x12 returns 32'h0000_8001.
- LH from +0x11, and a store with `funct3`=3'b101 → for each: `rsp_err_o`=1 at T+1, `rsp_rdata_o`=0, `stall_o` high only in cycle T, memory unchanged.
- SW 32'hDEAD_BEEF to `BASE_ADDR`+`DEPTH_WORDS`*4, and to `BASE_ADDR`−4 → `rsp_err_o`=1 for each; a following LW of `BASE_ADDR`+0 returns its prior value (no wrap-around write).
- `WAIT_CYCLES`=3, LW → `stall_o` high in cycles T..T+4 and `rsp_valid_o` in T+5. With `reset_i` raised at T+1 of an SW 32'hCAFE_F00D: no response, all outputs 0, and a subsequent LW returns 32'hCAFE_F00D.
